// File: rtl/nn_result_tx.sv
// nn_result_tx: captures one NUM_POS x 2-channel feature-map frame, then streams
// HEADER + payload (+ checksum byte when NN_RESULT_TX_CHECKSUM_EN is defined) over valid/ready.
module nn_result_tx #(
   parameter int                NUM_POS = 36,
   parameter int                DATA_W  = 8,
   parameter logic [DATA_W-1:0] HEADER  = 8'hA5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data_0,
   input  logic [DATA_W-1:0] in_data_1,
   input  logic              restart,
   input  logic              tx_ready,
   output logic              tx_valid,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_last,
   output logic              busy,
   output logic              overflow,
   output logic              frame_done
);

   localparam int               PTR_W    = (NUM_POS > 1) ? $clog2(NUM_POS) : 1;
   localparam int               IDX_W    = PTR_W + 1;
   localparam logic [PTR_W-1:0] LAST_POS = PTR_W'(NUM_POS - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * NUM_POS - 1);

`ifdef NN_RESULT_TX_CHECKSUM_EN
   typedef enum logic [2:0] {S_CAPTURE, S_HEADER, S_PAYLOAD, S_CHECKSUM, S_DONE} state_t;
`else
   typedef enum logic [2:0] {S_CAPTURE, S_HEADER, S_PAYLOAD, S_DONE} state_t;
`endif

   state_t            state_q, state_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
`ifdef NN_RESULT_TX_CHECKSUM_EN
   logic [DATA_W-1:0] sum_q, sum_d;
`endif
   logic              tx_valid_q, tx_valid_d;
   logic [DATA_W-1:0] tx_data_q, tx_data_d;
   logic              tx_last_q, tx_last_d;
   logic              busy_q, busy_d;
   logic              overflow_q, overflow_d;
   logic              frame_done_q, frame_done_d;

   logic              xfer;
   logic              frame_end;
   logic              wr_en;
   logic [IDX_W-1:0]  rd_addr;
   logic [PTR_W-1:0]  rd_pos;
   logic [DATA_W-1:0] rd_byte;
   logic [DATA_W-1:0] wr_data [2];
   logic [DATA_W-1:0] rd_data [2];

   assign xfer       = tx_valid_q && tx_ready;
   assign wr_en      = !reset && !restart && in_valid && (state_q == S_CAPTURE);
   assign wr_data[0] = in_data_0;
   assign wr_data[1] = in_data_1;

   // Address of the byte to present after the current transfer; even = ch0 bank, odd = ch1 bank.
   assign rd_addr = (state_q == S_PAYLOAD && rd_idx_q != LAST_IDX) ? rd_idx_q + 1'b1 : '0;
   assign rd_pos  = rd_addr[IDX_W-1:1];
   assign rd_byte = rd_data[rd_addr[0]];

   for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      logic [DATA_W-1:0] mem [NUM_POS];

      always_ff @(posedge clk) begin
         if (wr_en) begin
            mem[wr_ptr_q] <= wr_data[gi];
         end
      end

      assign rd_data[gi] = mem[rd_pos];
   end

   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      rd_idx_d     = rd_idx_q;
`ifdef NN_RESULT_TX_CHECKSUM_EN
      sum_d        = sum_q;
`endif
      tx_valid_d   = tx_valid_q;
      tx_data_d    = tx_data_q;
      tx_last_d    = tx_last_q;
      busy_d       = busy_q;
      overflow_d   = overflow_q;
      frame_done_d = 1'b0;
      frame_end    = 1'b0;

      if (restart && (state_q == S_CAPTURE || state_q == S_DONE)) begin
         // Re-arm: any partial capture is discarded.
         state_d    = S_CAPTURE;
         wr_ptr_d   = '0;
         rd_idx_d   = '0;
`ifdef NN_RESULT_TX_CHECKSUM_EN
         sum_d      = '0;
`endif
         overflow_d = 1'b0;
      end else begin
         if (in_valid && state_q != S_CAPTURE) begin
            overflow_d = 1'b1;
         end

         case (state_q)
            S_CAPTURE: begin
               if (in_valid) begin
                  if (wr_ptr_q == LAST_POS) begin
                     state_d    = S_HEADER;
                     wr_ptr_d   = '0;
                     rd_idx_d   = '0;
`ifdef NN_RESULT_TX_CHECKSUM_EN
                     sum_d      = '0;
`endif
                     tx_valid_d = 1'b1;
                     tx_data_d  = HEADER;
                     tx_last_d  = 1'b0;
                     busy_d     = 1'b1;
                  end else begin
                     wr_ptr_d = wr_ptr_q + 1'b1;
                  end
               end
            end

            S_HEADER: begin
               if (xfer) begin
                  state_d   = S_PAYLOAD;
                  tx_data_d = rd_byte;
                  tx_last_d = 1'b0;
               end
            end

            S_PAYLOAD: begin
               if (xfer) begin
`ifdef NN_RESULT_TX_CHECKSUM_EN
                  sum_d = sum_q + tx_data_q;
`endif
                  if (rd_idx_q == LAST_IDX) begin
`ifdef NN_RESULT_TX_CHECKSUM_EN
                     state_d   = S_CHECKSUM;
                     tx_data_d = sum_q + tx_data_q;
                     tx_last_d = 1'b1;
`else
                     frame_end = 1'b1;
`endif
                  end else begin
                     rd_idx_d  = rd_idx_q + 1'b1;
                     tx_data_d = rd_byte;
`ifndef NN_RESULT_TX_CHECKSUM_EN
                     tx_last_d = (rd_addr == LAST_IDX);
`endif
                  end
               end
            end

`ifdef NN_RESULT_TX_CHECKSUM_EN
            S_CHECKSUM: begin
               if (xfer) begin
                  frame_end = 1'b1;
               end
            end
`endif

            S_DONE: begin
            end

            default: begin
               state_d = S_CAPTURE;
            end
         endcase

         if (frame_end) begin
            state_d      = S_DONE;
            tx_valid_d   = 1'b0;
            tx_data_d    = '0;
            tx_last_d    = 1'b0;
            busy_d       = 1'b0;
            frame_done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_CAPTURE;
         wr_ptr_q     <= '0;
         rd_idx_q     <= '0;
`ifdef NN_RESULT_TX_CHECKSUM_EN
         sum_q        <= '0;
`endif
         tx_valid_q   <= 1'b0;
         tx_data_q    <= '0;
         tx_last_q    <= 1'b0;
         busy_q       <= 1'b0;
         overflow_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_idx_q     <= rd_idx_d;
`ifdef NN_RESULT_TX_CHECKSUM_EN
         sum_q        <= sum_d;
`endif
         tx_valid_q   <= tx_valid_d;
         tx_data_q    <= tx_data_d;
         tx_last_q    <= tx_last_d;
         busy_q       <= busy_d;
         overflow_q   <= overflow_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign tx_valid   = tx_valid_q;
   assign tx_data    = tx_data_q;
   assign tx_last    = tx_last_q;
   assign busy       = busy_q;
   assign overflow   = overflow_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_nn_result_tx.sv
// Randomised bench for nn_result_tx: the expected frame is built from the beats sent
// (header, pairs, mod-256 sum) and every output is compared on every cycle.
module tb_nn_result_tx;

   localparam int NUM_POS = 36;
`ifdef NN_RESULT_TX_CHECKSUM_EN
   localparam bit CK = 1'b1;
`else
   localparam bit CK = 1'b0;
`endif
   localparam int FRAME_LEN = 2 * NUM_POS + 1 + (CK ? 1 : 0);

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic [7:0] in_data_0;
   logic [7:0] in_data_1;
   logic       restart;
   logic       tx_ready;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_last;
   logic       busy;
   logic       overflow;
   logic       frame_done;

   nn_result_tx dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_data_0  (in_data_0),
      .in_data_1  (in_data_1),
      .restart    (restart),
      .tx_ready   (tx_ready),
      .tx_valid   (tx_valid),
      .tx_data    (tx_data),
      .tx_last    (tx_last),
      .busy       (busy),
      .overflow   (overflow),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         failures = 0;
   logic [7:0] d0 [NUM_POS];
   logic [7:0] d1 [NUM_POS];
   logic [7:0] exp_mem [FRAME_LEN];
   logic [7:0] rx_log [FRAME_LEN];
   logic [7:0] model_sum;
   bit         exp_active = 1'b0;
   bit         exp_ovf = 1'b0;
   bit         in_frame = 1'b0;
   bit         prev_stall = 1'b0;
   logic [7:0] prev_data = '0;
   logic       prev_last = 1'b0;
   bit         done_pend = 1'b0;
   int         done_cnt = 0;
   int         rx_idx = 0;
   int         xfer_cnt = 0;
   int         dut_len = 0;
   int         valid_cycles = 0;
   int         ready_mode = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   // Per-cycle comparison of every output against the frame model.
   task automatic monitor();
      if (reset) begin
         rx_idx     = 0;
         xfer_cnt   = 0;
         in_frame   = 1'b0;
         prev_stall = 1'b0;
         done_pend  = 1'b0;
         exp_active = 1'b0;
      end else begin
         chk("busy_vs_valid", busy, tx_valid);
         chk("frame_done", frame_done, done_pend);
         if (done_pend) done_cnt++;
         done_pend = 1'b0;
         chk("overflow", overflow, exp_ovf);
         if (prev_stall) begin
            chk("stall_valid", tx_valid, 1);
            chk("stall_data", tx_data, prev_data);
            chk("stall_last", tx_last, prev_last);
         end
         if (in_frame && !tx_valid) chk("no_bubble", tx_valid, 1);
         if (tx_valid) valid_cycles++;
         if (tx_valid && tx_ready) begin
            xfer_cnt++;
            if (tx_last) begin
               dut_len  = xfer_cnt;
               xfer_cnt = 0;
            end
            if (!exp_active) begin
               checks++;
               failures++;
               $display("FAIL unexpected_byte got=%0h expected=no transfer", tx_data);
            end else begin
               chk("data", tx_data, exp_mem[rx_idx]);
               chk("last", tx_last, rx_idx == FRAME_LEN - 1);
               rx_log[rx_idx] = tx_data;
               rx_idx++;
               in_frame = 1'b1;
               if (rx_idx == FRAME_LEN) begin
                  done_pend  = 1'b1;
                  in_frame   = 1'b0;
                  exp_active = 1'b0;
                  rx_idx     = 0;
               end
            end
         end
         prev_stall = tx_valid && !tx_ready;
         prev_data  = tx_data;
         prev_last  = tx_last;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
      case (ready_mode)
         0:       tx_ready = 1'b1;
         1:       tx_ready = ~tx_ready;
         default: tx_ready = ($urandom_range(0, 3) != 0);
      endcase
   endtask

   task automatic fill_t1();
      for (int p = 0; p < NUM_POS; p++) begin
         d0[p] = 8'(p);
         d1[p] = 8'(p + 100);
      end
   endtask

   task automatic fill_rand();
      for (int p = 0; p < NUM_POS; p++) begin
         d0[p] = 8'($urandom);
         d1[p] = 8'($urandom);
      end
   endtask

   task automatic build_frame();
      int s = 0;
      exp_mem[0] = 8'hA5;
      for (int p = 0; p < NUM_POS; p++) begin
         exp_mem[1 + 2 * p] = d0[p];
         exp_mem[2 + 2 * p] = d1[p];
         s += int'(d0[p]) + int'(d1[p]);
      end
      model_sum = 8'(s % 256);
`ifdef NN_RESULT_TX_CHECKSUM_EN
      exp_mem[FRAME_LEN - 1] = model_sum;
`endif
      exp_active = 1'b1;
   endtask

   task automatic send_frame(input bit gaps);
      for (int p = 0; p < NUM_POS; p++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               in_valid  = 1'b0;
               in_data_0 = 8'($urandom);
               tick();
            end
         end
         in_valid  = 1'b1;
         in_data_0 = d0[p];
         in_data_1 = d1[p];
         tick();
      end
      in_valid = 1'b0;
      chk("hdr_latency_valid", tx_valid, 1);
      chk("hdr_latency_data", tx_data, 8'hA5);
   endtask

   task automatic wait_done(input string name);
      int start = done_cnt;
      int n = 0;
      while (done_cnt == start && n < 1000) begin
         tick();
         n++;
      end
      chk({name, "_frame_done_seen"}, done_cnt - start, 1);
   endtask

   task automatic wait_xfers(input int target);
      int n = 0;
      while (rx_idx < target && n < 500) begin
         tick();
         n++;
      end
      chk("xfer_progress", rx_idx >= target, 1);
   endtask

   task automatic do_restart();
      restart = 1'b1;
      tick();
      restart = 1'b0;
      exp_ovf = 1'b0;
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_tx_valid"}, tx_valid, 0);
      chk({name, "_tx_data"}, tx_data, 0);
      chk({name, "_tx_last"}, tx_last, 0);
      chk({name, "_busy"}, busy, 0);
      chk({name, "_overflow"}, overflow, 0);
      chk({name, "_frame_done"}, frame_done, 0);
   endtask

   initial begin
      int vstart;
      int ee;
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data_0 = '0;
      in_data_1 = '0;
      restart   = 1'b0;
      tx_ready  = 1'b0;
      tick();
      tick();
      chk_all_zero("reset");
      reset = 1'b0;

      // Full frame, ready held high.
      ready_mode = 0;
      fill_t1();
      build_frame();
      chk("model_checksum", model_sum, 8'hFC);
      chk("model_byte2", exp_mem[2], 8'd100);
      vstart = valid_cycles;
      send_frame(1'b0);
      wait_done("t1");
      chk("t1_valid_cycles", valid_cycles - vstart, FRAME_LEN);
      chk("t1_first", rx_log[0], 8'hA5);
      chk("t1_byte1", rx_log[1], 8'h00);
      chk("t1_byte2", rx_log[2], 8'd100);
      chk("t1_tail", rx_log[FRAME_LEN - 1], CK ? 8'hFC : 8'h87);
      chk("t1_len", dut_len, CK ? 74 : 73);
      tick();
      tick();
      chk("t1_idle_valid", tx_valid, 0);

      // Same frame, alternating backpressure.
      do_restart();
      ready_mode = 1;
      fill_t1();
      build_frame();
      send_frame(1'b0);
      wait_done("t2");
      chk("t2_tail", rx_log[FRAME_LEN - 1], CK ? 8'hFC : 8'h87);

      // Overflow mid-payload, ignored restart, random data and ready.
      do_restart();
      ready_mode = 2;
      fill_rand();
      build_frame();
      send_frame(1'b1);
      wait_xfers(5);
      in_valid  = 1'b1;
      in_data_0 = 8'h55;
      tick();
      in_valid = 1'b0;
      exp_ovf  = 1'b1;
      chk("t3_overflow_set", overflow, 1);
      restart = 1'b1;
      tick();
      restart = 1'b0;
      wait_done("t3");
      chk("t3_overflow_sticky", overflow, 1);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      do_restart();
      chk("t3_overflow_cleared", overflow, 0);

      // Reset after 10 transfers, then a fresh frame.
      ready_mode = 0;
      fill_rand();
      build_frame();
      send_frame(1'b0);
      wait_xfers(10);
      reset = 1'b1;
      tick();
      chk_all_zero("midreset");
      reset   = 1'b0;
      exp_ovf = 1'b0;
      ready_mode = 2;
      fill_rand();
      build_frame();
      send_frame(1'b1);
      wait_done("t4");
      chk("t4_first", rx_log[0], 8'hA5);

      // Partial capture of 0xEE discarded by restart (restart beats the coincident beat).
      do_restart();
      ready_mode = 2;
      for (int i = 0; i < 5; i++) begin
         in_valid  = 1'b1;
         in_data_0 = 8'hEE;
         in_data_1 = 8'hEE;
         tick();
      end
      restart = 1'b1;
      tick();
      restart  = 1'b0;
      in_valid = 1'b0;
      fill_t1();
      build_frame();
      send_frame(1'b0);
      wait_done("t5");
      ee = 0;
      for (int i = 0; i < FRAME_LEN; i++) begin
         if (rx_log[i] == 8'hEE) ee++;
      end
      chk("t5_no_ee", ee, 0);
      chk("t5_tail", rx_log[FRAME_LEN - 1], CK ? 8'hFC : 8'h87);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
